// File: rtl/multi_alarm_if.sv
// Bundle between the time/alarm register file and the multi-alarm controller:
// time inputs, user pulses and the ringing/snooze status back to buzzer/display.
interface multi_alarm_if #(
  parameter int NUM_ALARMS = 4,
  parameter int TIME_W     = 32
);
  localparam int ID_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;

  logic                         i_Tick_1Hz;
  logic [TIME_W-1:0]            i_Time;
  logic [NUM_ALARMS*TIME_W-1:0] i_Alarm_Times;
  logic [NUM_ALARMS-1:0]        i_Alarm_Enable;
  logic                         i_Snooze;
  logic                         i_Dismiss;
  logic [NUM_ALARMS-1:0]        o_Ringing;
  logic [NUM_ALARMS-1:0]        o_Snoozed;
  logic                         o_Alarm_On;
  logic [ID_W-1:0]              o_Ringing_Id;
  logic                         o_Ringing_Valid;

  modport master (
    output i_Tick_1Hz, i_Time, i_Alarm_Times, i_Alarm_Enable, i_Snooze, i_Dismiss,
    input  o_Ringing, o_Snoozed, o_Alarm_On, o_Ringing_Id, o_Ringing_Valid
  );

  modport slave (
    input  i_Tick_1Hz, i_Time, i_Alarm_Times, i_Alarm_Enable, i_Snooze, i_Dismiss,
    output o_Ringing, o_Snoozed, o_Alarm_On, o_Ringing_Id, o_Ringing_Valid
  );
endinterface

// File: rtl/multi_alarm_controller.sv
// NUM_ALARMS independent IDLE/RING/SNOOZE channels with 1 Hz ring timeout,
// snooze timer, snooze limit and lowest-index arbitration of snooze/dismiss.
module multi_alarm_controller #(
  parameter int NUM_ALARMS           = 4,
  parameter int TIME_W               = 32,
  parameter int SNOOZE_SECONDS       = 300,
  parameter int RING_TIMEOUT_SECONDS = 60,
  parameter int MAX_SNOOZES          = 3
) (
  input logic          i_Clk,
  input logic          i_Reset_n,
  multi_alarm_if.slave bus
);
  localparam int ID_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;
  localparam int RC_W = $clog2(RING_TIMEOUT_SECONDS + 1);
  localparam int SC_W = $clog2(SNOOZE_SECONDS + 1);
  localparam int SN_W = $clog2(MAX_SNOOZES + 2);

  typedef enum logic [1:0] {ST_IDLE, ST_RING, ST_SNOOZE} state_t;

  logic [NUM_ALARMS-1:0] ringing;
  logic [NUM_ALARMS-1:0] snoozed;
  logic [ID_W-1:0]       sel;
  logic                  sel_vld;

  // Lowest-index ringing channel owns the user buttons.
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    for (int k = NUM_ALARMS - 1; k >= 0; k--) begin
      if (ringing[k]) begin
        sel     = ID_W'(k);
        sel_vld = 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NUM_ALARMS; k++) begin : g_ch
    state_t          state;
    logic            en;
    logic            hit;
    logic            hit_d;
    logic            trig;
    logic            is_sel;
    logic [RC_W-1:0] ring_cnt;
    logic [SC_W-1:0] snz_cnt;
    logic [SN_W-1:0] snooze_num;

    assign en     = bus.i_Alarm_Enable[k];
    assign hit    = en && (bus.i_Time == bus.i_Alarm_Times[k*TIME_W +: TIME_W]);
    assign trig   = hit && !hit_d;
    assign is_sel = sel_vld && (sel == ID_W'(k));

    // User events are checked before the tick, so a coincident tick is consumed.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
        state      <= ST_IDLE;
        hit_d      <= 1'b0;
        ring_cnt   <= '0;
        snz_cnt    <= '0;
        snooze_num <= '0;
      end else begin
        hit_d <= hit;
        case (state)
          ST_IDLE: begin
            if (trig) begin
              state      <= ST_RING;
              ring_cnt   <= '0;
              snooze_num <= '0;
            end
          end
          ST_RING: begin
            if (!en) begin
              state <= ST_IDLE;
            end else if (is_sel && bus.i_Dismiss) begin
              state <= ST_IDLE;
            end else if (is_sel && bus.i_Snooze && (snooze_num == SN_W'(MAX_SNOOZES))) begin
              state <= ST_IDLE;
            end else if (is_sel && bus.i_Snooze) begin
              state      <= ST_SNOOZE;
              snooze_num <= snooze_num + SN_W'(1);
              snz_cnt    <= '0;
            end else if (bus.i_Tick_1Hz) begin
              if (ring_cnt == RC_W'(RING_TIMEOUT_SECONDS - 1)) begin
                state <= ST_IDLE;
              end else begin
                ring_cnt <= ring_cnt + RC_W'(1);
              end
            end
          end
          ST_SNOOZE: begin
            if (!en) begin
              state <= ST_IDLE;
            end else if (bus.i_Tick_1Hz) begin
              if (snz_cnt == SC_W'(SNOOZE_SECONDS - 1)) begin
                state    <= ST_RING;
                ring_cnt <= '0;
              end else begin
                snz_cnt <= snz_cnt + SC_W'(1);
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end

    assign ringing[k] = (state == ST_RING);
    assign snoozed[k] = (state == ST_SNOOZE);
  end

  assign bus.o_Ringing       = ringing;
  assign bus.o_Snoozed       = snoozed;
  assign bus.o_Alarm_On      = |ringing;
  assign bus.o_Ringing_Id    = sel;
  assign bus.o_Ringing_Valid = |ringing;
endmodule

// File: tb/tb_multi_alarm_controller.sv
// Scoreboard bench for multi_alarm_controller: a countdown-based reference
// model predicts every cycle's outputs, a monitor pops and compares them.
module tb_multi_alarm_controller;
  localparam int N    = 4;
  localparam int TW   = 32;
  localparam int SNZ  = 5;
  localparam int RING = 10;
  localparam int MAXS = 2;

  localparam logic [31:0] T_A = 32'h00060000;  // ch0 and ch3
  localparam logic [31:0] T_B = 32'h00073000;  // ch1
  localparam logic [31:0] T_C = 32'h00080000;  // ch2

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] s;
    logic       on;
    logic [1:0] id;
    logic       vld;
  } obs_t;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  obs_t exp_q[$];

  multi_alarm_if #(.NUM_ALARMS(N), .TIME_W(TW)) bus ();

  multi_alarm_controller #(
    .NUM_ALARMS(N), .TIME_W(TW), .SNOOZE_SECONDS(SNZ),
    .RING_TIMEOUT_SECONDS(RING), .MAX_SNOOZES(MAXS)
  ) dut (
    .i_Clk(clk), .i_Reset_n(rst_n), .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: 0 = idle, 1 = ringing, 2 = snoozed; times kept as seconds left.
  int mode[N]      = '{default: 0};
  int ring_left[N] = '{default: 0};
  int snz_left[N]  = '{default: 0};
  int used[N]      = '{default: 0};
  bit hit_prev[N]  = '{default: 0};

  function automatic obs_t model_obs();
    obs_t o;
    o = '0;
    for (int k = 0; k < N; k++) begin
      o.r[k] = (mode[k] == 1);
      o.s[k] = (mode[k] == 2);
    end
    o.on  = |o.r;
    o.vld = |o.r;
    for (int k = N - 1; k >= 0; k--) if (o.r[k]) o.id = 2'(k);
    return o;
  endfunction

  task automatic model_step();
    int sel;
    bit hit;
    sel = -1;
    for (int k = N - 1; k >= 0; k--) if (mode[k] == 1) sel = k;
    for (int k = 0; k < N; k++) begin
      hit = bus.i_Alarm_Enable[k] && (bus.i_Time == bus.i_Alarm_Times[k*TW +: TW]);
      if (mode[k] == 0) begin
        if (hit && !hit_prev[k]) begin
          mode[k] = 1; ring_left[k] = RING; used[k] = 0;
        end
      end else if (!bus.i_Alarm_Enable[k]) begin
        mode[k] = 0;
      end else if (mode[k] == 1) begin
        if (k == sel && bus.i_Dismiss) mode[k] = 0;
        else if (k == sel && bus.i_Snooze) begin
          if (used[k] >= MAXS) mode[k] = 0;
          else begin mode[k] = 2; used[k]++; snz_left[k] = SNZ; end
        end else if (bus.i_Tick_1Hz) begin
          ring_left[k]--;
          if (ring_left[k] == 0) mode[k] = 0;
        end
      end else if (bus.i_Tick_1Hz) begin
        snz_left[k]--;
        if (snz_left[k] == 0) begin mode[k] = 1; ring_left[k] = RING; end
      end
      hit_prev[k] = hit;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (rst_n !== 1'b1) begin
        for (int k = 0; k < N; k++) begin
          mode[k] = 0; ring_left[k] = 0; snz_left[k] = 0; used[k] = 0; hit_prev[k] = 0;
        end
        exp_q.delete();
      end else begin
        model_step();
        exp_q.push_back(model_obs());
      end
    end
  end

  // Monitor: one prediction per clock, or all-zero outputs while in reset.
  initial begin
    obs_t a, e;
    forever begin
      @(negedge clk);
      a = {bus.o_Ringing, bus.o_Snoozed, bus.o_Alarm_On, bus.o_Ringing_Id, bus.o_Ringing_Valid};
      n_checks++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (a !== e) begin
          n_fail++;
          $display("FAIL scoreboard t=%0t got r=%b s=%b on=%b id=%0d v=%b want r=%b s=%b on=%b id=%0d v=%b",
                   $time, a.r, a.s, a.on, a.id, a.vld, e.r, e.s, e.on, e.id, e.vld);
        end
      end else if (rst_n !== 1'b1) begin
        if (a !== '0) begin
          n_fail++;
          $display("FAIL reset_outputs t=%0t got %h want 0", $time, a);
        end
      end else begin
        n_fail++;
        $display("FAIL scoreboard_empty t=%0t got %h want a queued prediction", $time, a);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got %h want %h", name, $time, act, exp);
    end
  endtask

  // Called at a falling edge; holds pulses for exactly one rising edge.
  task automatic drive(input bit t, input bit s, input bit d);
    bus.i_Tick_1Hz = t;
    bus.i_Snooze   = s;
    bus.i_Dismiss  = d;
    @(negedge clk);
    bus.i_Tick_1Hz = 1'b0;
    bus.i_Snooze   = 1'b0;
    bus.i_Dismiss  = 1'b0;
  endtask

  task automatic arm(input logic [3:0] en, input logic [31:0] t);
    bus.i_Time         = '0;
    bus.i_Alarm_Enable = en;
    drive(0, 0, 0);
    bus.i_Time = t;
    drive(0, 0, 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t got no finish want finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n              = 1'b0;
    bus.i_Tick_1Hz     = 1'b0;
    bus.i_Snooze       = 1'b0;
    bus.i_Dismiss      = 1'b0;
    bus.i_Time         = '0;
    bus.i_Alarm_Enable = '0;
    bus.i_Alarm_Times  = {T_A, T_C, T_B, T_A};
    repeat (3) @(negedge clk);
    chk("reset_alarm_on", 32'(bus.o_Alarm_On), 32'd0);
    chk("reset_ringing", 32'(bus.o_Ringing), 32'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Basic trigger and dismiss on ch1
    arm(4'b0010, T_B);
    chk("basic_ringing", 32'(bus.o_Ringing), 32'h2);
    chk("basic_id", 32'(bus.o_Ringing_Id), 32'd1);
    drive(0, 0, 1);
    chk("basic_dismiss", 32'(bus.o_Ringing), 32'h0);
    repeat (3) drive(0, 0, 0);
    chk("basic_no_rering", 32'(bus.o_Ringing), 32'h0);

    // Snooze limit on ch0
    arm(4'b0001, T_A);
    chk("snz_ring", 32'(bus.o_Ringing), 32'h1);
    drive(0, 1, 0);
    chk("snz_first", 32'(bus.o_Snoozed), 32'h1);
    ticks(SNZ - 1);
    chk("snz_hold", 32'(bus.o_Snoozed), 32'h1);
    ticks(1);
    chk("snz_rering1", 32'(bus.o_Ringing), 32'h1);
    drive(0, 1, 0);
    chk("snz_second", 32'(bus.o_Snoozed), 32'h1);
    ticks(SNZ);
    chk("snz_rering2", 32'(bus.o_Ringing), 32'h1);
    drive(0, 1, 0);
    chk("snz_limit_ring", 32'(bus.o_Ringing), 32'h0);
    chk("snz_limit_snoozed", 32'(bus.o_Snoozed), 32'h0);

    // Ring timeout on ch2, then tick coincident with dismiss
    arm(4'b0100, T_C);
    ticks(RING - 1);
    chk("timeout_hold", 32'(bus.o_Ringing), 32'h4);
    ticks(1);
    chk("timeout_fire", 32'(bus.o_Ringing), 32'h0);
    arm(4'b0100, T_C);
    drive(1, 0, 1);
    chk("tick_dismiss", 32'(bus.o_Ringing), 32'h0);
    arm(4'b0100, T_C);
    ticks(RING - 1);
    chk("timeout_full_again", 32'(bus.o_Ringing), 32'h4);
    drive(0, 0, 1);

    // Priority between ch0 and ch3
    arm(4'b1001, T_A);
    chk("prio_ringing", 32'(bus.o_Ringing), 32'h9);
    chk("prio_id0", 32'(bus.o_Ringing_Id), 32'd0);
    drive(0, 0, 1);
    chk("prio_after_dismiss", 32'(bus.o_Ringing), 32'h8);
    chk("prio_id3", 32'(bus.o_Ringing_Id), 32'd3);
    drive(0, 1, 1);
    chk("prio_both_ring", 32'(bus.o_Ringing), 32'h0);
    chk("prio_both_snz", 32'(bus.o_Snoozed), 32'h0);

    // Enable edge cases, then reset mid-ring
    bus.i_Alarm_Enable = 4'b0000;
    bus.i_Time         = T_B;
    drive(0, 0, 0);
    chk("en_disabled", 32'(bus.o_Ringing), 32'h0);
    bus.i_Alarm_Enable = 4'b0010;
    drive(0, 0, 0);
    chk("en_fires", 32'(bus.o_Ringing), 32'h2);
    repeat (2) drive(0, 0, 0);
    chk("en_once", 32'(bus.o_Ringing), 32'h2);
    drive(0, 1, 0);
    chk("en_snoozed", 32'(bus.o_Snoozed), 32'h2);
    bus.i_Alarm_Enable = 4'b0000;
    drive(0, 0, 0);
    chk("en_off_snoozed", 32'(bus.o_Snoozed), 32'h0);
    bus.i_Alarm_Enable = 4'b0010;
    drive(0, 0, 0);
    chk("pre_reset_ring", 32'(bus.o_Alarm_On), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("async_reset_on", 32'(bus.o_Alarm_On), 32'd0);
    chk("async_reset_ring", 32'(bus.o_Ringing), 32'h0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Randomised traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) bus.i_Alarm_Enable = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0: bus.i_Time = '0;
          1: bus.i_Time = T_A;
          2: bus.i_Time = T_B;
          default: bus.i_Time = T_C;
        endcase
      end
      drive($urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0);
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
